// File: rtl/punc_control_pkg.sv
// Shared encodings for the PUnC control unit: opcodes, FSM states, datapath selects.
// Pure definitions; no logic, no latency.
// No flow control; consumers import the symbols they need.
package punc_control_pkg;

  // LC-3 opcodes (ir[15:12])
  localparam logic [3:0] OP_BR   = 4'b0000;
  localparam logic [3:0] OP_ADD  = 4'b0001;
  localparam logic [3:0] OP_LD   = 4'b0010;
  localparam logic [3:0] OP_ST   = 4'b0011;
  localparam logic [3:0] OP_JSR  = 4'b0100;
  localparam logic [3:0] OP_AND  = 4'b0101;
  localparam logic [3:0] OP_LDR  = 4'b0110;
  localparam logic [3:0] OP_STR  = 4'b0111;
  localparam logic [3:0] OP_RTI  = 4'b1000;
  localparam logic [3:0] OP_NOT  = 4'b1001;
  localparam logic [3:0] OP_LDI  = 4'b1010;
  localparam logic [3:0] OP_STI  = 4'b1011;
  localparam logic [3:0] OP_JMP  = 4'b1100;
  localparam logic [3:0] OP_RES  = 4'b1101;
  localparam logic [3:0] OP_LEA  = 4'b1110;
  localparam logic [3:0] OP_HALT = 4'b1111;

  typedef enum logic [2:0] {
    ST_INIT, ST_FETCH, ST_DECODE, ST_EXEC, ST_EXEC2, ST_HALT
  } state_e;

  // PC next-value select
  localparam logic [1:0] PC_SEL_OFF9  = 2'd0;
  localparam logic [1:0] PC_SEL_OFF11 = 2'd1;
  localparam logic [1:0] PC_SEL_RQ    = 2'd2;

  // Memory read address select
  localparam logic [1:0] DMEM_R_PC       = 2'd0;
  localparam logic [1:0] DMEM_R_PC_OFF9  = 2'd1;
  localparam logic [1:0] DMEM_R_RP       = 2'd2;
  localparam logic [1:0] DMEM_R_RQ_OFF6  = 2'd3;

  // Memory write address select
  localparam logic [1:0] DMEM_W_PC_OFF9  = 2'd0;
  localparam logic [1:0] DMEM_W_TEMP     = 2'd1;
  localparam logic [1:0] DMEM_W_RQ_OFF6  = 2'd2;

  // Register-file write data / address select
  localparam logic [1:0] RF_WD_ALU     = 2'd0;
  localparam logic [1:0] RF_WD_PC_OFF9 = 2'd1;
  localparam logic [1:0] RF_WD_DMEM    = 2'd2;
  localparam logic [1:0] RF_WD_PC      = 2'd3;
  localparam logic       RF_WA_R7      = 1'b0;
  localparam logic       RF_WA_DR      = 1'b1;

  // Rp read address select
  localparam logic       RF_RP_DR  = 1'b0;  // ir[11:9]
  localparam logic       RF_RP_SR2 = 1'b1;  // ir[2:0]

  // ALU function and A-input select
  localparam logic [1:0] ALU_PASSA = 2'd0;
  localparam logic [1:0] ALU_ADD   = 2'd1;
  localparam logic [1:0] ALU_AND   = 2'd2;
  localparam logic [1:0] ALU_NOT   = 2'd3;
  localparam logic       ALU_A_RP   = 1'b0;
  localparam logic       ALU_A_IMM5 = 1'b1;

  // Branch condition bit positions within ir
  localparam int BR_N = 11;
  localparam int BR_Z = 10;
  localparam int BR_P = 9;

endpackage

// File: rtl/punc_control.sv
// PUnC LC-3 control FSM: sequences FETCH/DECODE/EXEC(/EXEC2) and drives all datapath controls.
// 3 cycles per instruction, 4 for LDI/STI; outputs are combinational from state and ir.
// No backpressure: memory is combinational-read, so the FSM never stalls; HALT holds until rst.
module punc_control
  import punc_control_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [15:0] ir,
  input  logic       nzp_match,
  output logic       pc_ld,
  output logic       pc_clr,
  output logic       pc_inc,
  output logic [1:0] pc_sel,
  output logic       ir_ld,
  output logic       ir_clr,
  output logic       dmem_rd,
  output logic       dmem_wr,
  output logic [1:0] dmem_r_addr_sel,
  output logic [1:0] dmem_w_addr_sel,
  output logic [1:0] rf_w_data_sel,
  output logic       rf_w_addr_sel,
  output logic       rf_w_wr,
  output logic       rf_rp_addr_sel,
  output logic       rf_rp_rd,
  output logic       rf_rq_rd,
  output logic       temp_ld,
  output logic       nzp_ld,
  output logic       nzp_clr,
  output logic [1:0] alu_sel,
  output logic       alu_in_a_sel,
  output logic       halted
);

  state_e     state_q, state_d;
  logic [3:0] opcode;

  assign opcode = ir[15:12];

  // Operand fields are consumed by the datapath, not here.
  logic unused_ir_bits;
  assign unused_ir_bits = ^{ir[10:6], ir[4:0]};

  // State register; reset forces INIT so the next instruction starts cleanly.
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_INIT;
    else     state_q <= state_d;
  end

  // Next-state and control decode; every output defaults low.
  always_comb begin
    state_d         = state_q;
    pc_ld           = 1'b0;
    pc_clr          = 1'b0;
    pc_inc          = 1'b0;
    pc_sel          = PC_SEL_OFF9;
    ir_ld           = 1'b0;
    ir_clr          = 1'b0;
    dmem_rd         = 1'b0;
    dmem_wr         = 1'b0;
    dmem_r_addr_sel = DMEM_R_PC;
    dmem_w_addr_sel = DMEM_W_PC_OFF9;
    rf_w_data_sel   = RF_WD_ALU;
    rf_w_addr_sel   = RF_WA_R7;
    rf_w_wr         = 1'b0;
    rf_rp_addr_sel  = RF_RP_DR;
    rf_rp_rd        = 1'b0;
    rf_rq_rd        = 1'b0;
    temp_ld         = 1'b0;
    nzp_ld          = 1'b0;
    nzp_clr         = 1'b0;
    alu_sel         = ALU_PASSA;
    alu_in_a_sel    = ALU_A_RP;
    halted          = 1'b0;

    unique case (state_q)
      ST_INIT: begin
        pc_clr  = 1'b1;
        ir_clr  = 1'b1;
        nzp_clr = 1'b1;
        state_d = ST_FETCH;
      end

      ST_FETCH: begin
        dmem_rd         = 1'b1;
        dmem_r_addr_sel = DMEM_R_PC;
        ir_ld           = 1'b1;
        pc_inc          = 1'b1;
        state_d         = ST_DECODE;
      end

      ST_DECODE: begin
        state_d = (opcode == OP_HALT) ? ST_HALT : ST_EXEC;
      end

      ST_EXEC: begin
        state_d = ST_FETCH;
        case (opcode)
          OP_ADD, OP_AND: begin
            rf_rp_addr_sel = RF_RP_SR2;
            alu_in_a_sel   = ir[5];
            alu_sel        = (opcode == OP_ADD) ? ALU_ADD : ALU_AND;
            rf_w_data_sel  = RF_WD_ALU;
            rf_w_addr_sel  = RF_WA_DR;
            rf_w_wr        = 1'b1;
            nzp_ld         = 1'b1;
            rf_rp_rd       = 1'b1;
            rf_rq_rd       = 1'b1;
          end
          OP_NOT: begin
            alu_sel       = ALU_NOT;
            rf_rq_rd      = 1'b1;
            rf_w_data_sel = RF_WD_ALU;
            rf_w_addr_sel = RF_WA_DR;
            rf_w_wr       = 1'b1;
            nzp_ld        = 1'b1;
          end
          OP_BR: begin
            if (nzp_match) begin
              pc_ld  = 1'b1;
              pc_sel = PC_SEL_OFF9;
            end
          end
          OP_JMP: begin
            pc_ld    = 1'b1;
            pc_sel   = PC_SEL_RQ;
            rf_rq_rd = 1'b1;
          end
          OP_JSR: begin
            // R7 captures the already-incremented PC in the same edge the PC jumps.
            rf_w_addr_sel = RF_WA_R7;
            rf_w_data_sel = RF_WD_PC;
            rf_w_wr       = 1'b1;
            pc_ld         = 1'b1;
            pc_sel        = ir[11] ? PC_SEL_OFF11 : PC_SEL_RQ;
            rf_rq_rd      = 1'b1;
          end
          OP_LD, OP_LDR, OP_LDI: begin
            dmem_rd         = 1'b1;
            dmem_r_addr_sel = (opcode == OP_LDR) ? DMEM_R_RQ_OFF6 : DMEM_R_PC_OFF9;
            rf_rq_rd        = (opcode == OP_LDR);
            rf_w_data_sel   = RF_WD_DMEM;
            rf_w_addr_sel   = RF_WA_DR;
            rf_w_wr         = 1'b1;
            // LDI parks the pointer in DR; flags are set only by the final load.
            nzp_ld          = (opcode != OP_LDI);
            if (opcode == OP_LDI) state_d = ST_EXEC2;
          end
          OP_LEA: begin
            rf_w_data_sel = RF_WD_PC_OFF9;
            rf_w_addr_sel = RF_WA_DR;
            rf_w_wr       = 1'b1;
            nzp_ld        = 1'b1;
          end
          OP_ST, OP_STR: begin
            dmem_wr         = 1'b1;
            dmem_w_addr_sel = (opcode == OP_STR) ? DMEM_W_RQ_OFF6 : DMEM_W_PC_OFF9;
            rf_rq_rd        = (opcode == OP_STR);
            rf_rp_addr_sel  = RF_RP_DR;
            rf_rp_rd        = 1'b1;
          end
          OP_STI: begin
            dmem_rd         = 1'b1;
            dmem_r_addr_sel = DMEM_R_PC_OFF9;
            temp_ld         = 1'b1;
            state_d         = ST_EXEC2;
          end
          default: ;  // RTI / reserved behave as NOP
        endcase
      end

      ST_EXEC2: begin
        state_d        = ST_FETCH;
        rf_rp_addr_sel = RF_RP_DR;
        rf_rp_rd       = 1'b1;
        if (opcode == OP_LDI) begin
          dmem_rd         = 1'b1;
          dmem_r_addr_sel = DMEM_R_RP;
          rf_w_data_sel   = RF_WD_DMEM;
          rf_w_addr_sel   = RF_WA_DR;
          rf_w_wr         = 1'b1;
          nzp_ld          = 1'b1;
        end else begin
          dmem_wr         = 1'b1;
          dmem_w_addr_sel = DMEM_W_TEMP;
        end
      end

      ST_HALT: begin
        halted  = 1'b1;
        state_d = ST_HALT;
      end

      default: state_d = ST_INIT;
    endcase
  end

endmodule

// File: tb/tb_punc_control.sv
// Scoreboard bench for punc_control: a driver walks instructions through their phases and
// queues the expected control word for each cycle; a negedge monitor pops and compares.
// Expectations come from an instruction-level model of the LC-3 control semantics.
module tb_punc_control;

  logic clk = 1'b0;
  logic rst;
  logic [15:0] ir;
  logic nzp_match;
  logic pc_ld, pc_clr, pc_inc, ir_ld, ir_clr, dmem_rd, dmem_wr;
  logic [1:0] pc_sel, dmem_r_addr_sel, dmem_w_addr_sel, rf_w_data_sel, alu_sel;
  logic rf_w_addr_sel, rf_w_wr, rf_rp_addr_sel, rf_rp_rd, rf_rq_rd;
  logic temp_ld, nzp_ld, nzp_clr, alu_in_a_sel, halted;

  always #5 clk = ~clk;

  punc_control dut (
    .clk(clk), .rst(rst), .ir(ir), .nzp_match(nzp_match),
    .pc_ld(pc_ld), .pc_clr(pc_clr), .pc_inc(pc_inc), .pc_sel(pc_sel),
    .ir_ld(ir_ld), .ir_clr(ir_clr), .dmem_rd(dmem_rd), .dmem_wr(dmem_wr),
    .dmem_r_addr_sel(dmem_r_addr_sel), .dmem_w_addr_sel(dmem_w_addr_sel),
    .rf_w_data_sel(rf_w_data_sel), .rf_w_addr_sel(rf_w_addr_sel), .rf_w_wr(rf_w_wr),
    .rf_rp_addr_sel(rf_rp_addr_sel), .rf_rp_rd(rf_rp_rd), .rf_rq_rd(rf_rq_rd),
    .temp_ld(temp_ld), .nzp_ld(nzp_ld), .nzp_clr(nzp_clr), .alu_sel(alu_sel),
    .alu_in_a_sel(alu_in_a_sel), .halted(halted)
  );

  typedef struct packed {
    logic       pc_ld, pc_clr, pc_inc;
    logic [1:0] pc_sel;
    logic       ir_ld, ir_clr, dmem_rd, dmem_wr;
    logic [1:0] r_addr, w_addr, w_data;
    logic       w_addr_sel, w_wr, rp_sel, rp_rd, rq_rd, temp_ld, nzp_ld, nzp_clr;
    logic [1:0] alu_sel;
    logic       alu_a, halted;
  } ctl_t;

  typedef struct {
    ctl_t        c;
    logic [15:0] i;
    string       phase;
  } exp_t;

  ctl_t got;
  assign got = {pc_ld, pc_clr, pc_inc, pc_sel, ir_ld, ir_clr, dmem_rd, dmem_wr,
                dmem_r_addr_sel, dmem_w_addr_sel, rf_w_data_sel, rf_w_addr_sel, rf_w_wr,
                rf_rp_addr_sel, rf_rp_rd, rf_rq_rd, temp_ld, nzp_ld, nzp_clr,
                alu_sel, alu_in_a_sel, halted};

  exp_t exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;
  bit   mon_en = 0;

  // Instruction-level model: what each phase of an instruction must ask of the datapath.
  function automatic ctl_t model(input string phase, input logic [15:0] i, input logic m);
    ctl_t c;
    logic [3:0] op;
    c  = '0;
    op = i[15:12];
    if (phase == "INIT") begin
      c.pc_clr = 1; c.ir_clr = 1; c.nzp_clr = 1;
    end else if (phase == "FETCH") begin
      c.dmem_rd = 1; c.ir_ld = 1; c.pc_inc = 1;          // read at PC (addr sel 0)
    end else if (phase == "HALT") begin
      c.halted = 1;
    end else if (phase == "EXEC") begin
      case (op)
        4'h1, 4'h5: begin                                  // ADD / AND: DR <- SR1 op (SR2|imm5)
          c.rp_sel = 1; c.alu_a = i[5]; c.alu_sel = (op == 4'h1) ? 2'd1 : 2'd2;
          c.w_addr_sel = 1; c.w_wr = 1; c.nzp_ld = 1; c.rp_rd = 1; c.rq_rd = 1;
        end
        4'h9: begin                                        // NOT: DR <- ~SR
          c.alu_sel = 2'd3; c.rq_rd = 1; c.w_addr_sel = 1; c.w_wr = 1; c.nzp_ld = 1;
        end
        4'h0: c.pc_ld = m;                                 // BR: PC+off9 only if taken
        4'hC: begin c.pc_ld = 1; c.pc_sel = 2; c.rq_rd = 1; end
        4'h4: begin                                        // JSR/JSRR: R7 <- PC, jump
          c.w_data = 3; c.w_wr = 1; c.pc_ld = 1; c.rq_rd = 1;
          c.pc_sel = i[11] ? 2'd1 : 2'd2;
        end
        4'h2, 4'h6, 4'hA: begin                            // LD / LDR / LDI(first half)
          c.dmem_rd = 1; c.w_data = 2; c.w_addr_sel = 1; c.w_wr = 1;
          c.r_addr = (op == 4'h6) ? 2'd3 : 2'd1;
          c.rq_rd  = (op == 4'h6);
          c.nzp_ld = (op != 4'hA);
        end
        4'hE: begin c.w_data = 1; c.w_addr_sel = 1; c.w_wr = 1; c.nzp_ld = 1; end
        4'h3, 4'h7: begin                                  // ST / STR: mem <- DR
          c.dmem_wr = 1; c.rp_rd = 1;
          c.w_addr = (op == 4'h7) ? 2'd2 : 2'd0;
          c.rq_rd  = (op == 4'h7);
        end
        4'hB: begin c.dmem_rd = 1; c.r_addr = 1; c.temp_ld = 1; end
        default: ;                                         // 1000, 1101: NOP
      endcase
    end else if (phase == "EXEC2") begin
      c.rp_rd = 1;
      if (op == 4'hA) begin                                // LDI: DR <- mem[DR]
        c.dmem_rd = 1; c.r_addr = 2; c.w_data = 2; c.w_addr_sel = 1; c.w_wr = 1; c.nzp_ld = 1;
      end else begin                                       // STI: mem[Temp] <- DR
        c.dmem_wr = 1; c.w_addr = 1;
      end
    end
    return c;
  endfunction

  task automatic push(input string phase);
    exp_t e;
    e.c = model(phase, ir, nzp_match);
    e.i = ir;
    e.phase = phase;
    exp_q.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One instruction from FETCH onward; optionally reset during its first EXEC cycle.
  task automatic run_instr(input logic [15:0] i, input logic m, input bit rst_in_exec);
    int n_exec;
    ir = i;
    nzp_match = m;
    push("FETCH");  step();
    push("DECODE"); step();
    if (i[15:12] == 4'hF) begin
      repeat (4) begin push("HALT"); step(); end
      rst = 1; push("HALT"); step();
      rst = 0; push("INIT"); step();
      return;
    end
    push("EXEC");
    if (rst_in_exec) begin
      rst = 1; step();
      rst = 0; push("INIT"); step();
      return;
    end
    step();
    n_exec = (i[15:12] == 4'hA || i[15:12] == 4'hB) ? 2 : 1;
    if (n_exec == 2) begin push("EXEC2"); step(); end
  endtask

  // Monitor: every cycle while enabled, the DUT must match the oldest queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL underflow: got=%h required=<queued expectation>", got);
        end else begin
          e = exp_q.pop_front();
          if (got !== e.c) begin
            miscompares++;
            $display("FAIL %s ir=%h: got=%h required=%h", e.phase, e.i, got, e.c);
          end
        end
      end
    end
  end

  // Watchdog so the bench can never hang.
  initial begin
    #500000;
    $display("FAIL watchdog: got=timeout required=completion");
    miscompares++;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $fatal(1);
  end

  initial begin
    logic [15:0] r;
    rst = 1; ir = 16'h0000; nzp_match = 0;
    step();
    mon_en = 1;
    push("INIT"); step();              // rst still high through the second edge
    rst = 0;
    push("INIT"); step();

    // Directed cases
    run_instr(16'h1261, 1'b0, 0);      // ADD R1,R1,#1
    run_instr(16'h0402, 1'b1, 0);      // BRz taken
    run_instr(16'h0402, 1'b0, 0);      // BRz not taken
    run_instr(16'h4805, 1'b0, 0);      // JSR
    run_instr(16'h4080, 1'b0, 0);      // JSRR R2
    run_instr(16'hA203, 1'b0, 0);      // LDI
    run_instr(16'hB203, 1'b0, 0);      // STI
    run_instr(16'h5042, 1'b0, 0);      // AND register form
    run_instr(16'h8000, 1'b1, 0);      // RTI slot as NOP
    run_instr(16'hD000, 1'b1, 0);      // reserved as NOP
    run_instr(16'hA203, 1'b0, 1);      // reset during LDI EXEC
    run_instr(16'hF025, 1'b0, 0);      // HALT, then reset out

    // Random instruction stream
    for (int k = 0; k < 300; k++) begin
      r = 16'($urandom);
      run_instr(r, 1'($urandom_range(0, 1)), ($urandom_range(0, 19) == 0));
    end

    mon_en = 0;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL leftover: got=%0d pending required=0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
